// File: rtl/alarm_trigger.sv
// alarm_trigger
//   Decides when the alarm rings, handles snooze and dismiss, stops ringing
//   after a timeout and produces the gated buzzer square wave.
//   Time stamps count hundredths of a second since midnight (0..MAX_COUNT-1).
//
// Ports
//   i_Clk_5MHz          system clock
//   i_Reset_n           asynchronous active-low reset
//   i_Alarm_Enable      level, alarm armed when 1
//   i_Snooze            single-cycle snooze pulse
//   i_Dismiss           single-cycle dismiss pulse
//   i_Time_Stamp        current time stamp
//   i_Alarm_Time_Stamp  alarm time stamp
//   o_Alarm_Active      1 while ringing
//   o_Snooze_Active     1 while snoozing
//   o_Buzzer            tone gated by the on/off cadence
//   o_State             0 = IDLE, 1 = RINGING, 2 = SNOOZE
module alarm_trigger #(
    parameter int unsigned MAX_COUNT     = 8640000,
    parameter int unsigned SNOOZE_TICKS  = 30000,
    parameter int unsigned RING_TIMEOUT  = 6000,
    parameter int unsigned CADENCE_TICKS = 50,
    parameter int unsigned TONE_DIV      = 2500
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset_n,
    input  logic        i_Alarm_Enable,
    input  logic        i_Snooze,
    input  logic        i_Dismiss,
    input  logic [23:0] i_Time_Stamp,
    input  logic [23:0] i_Alarm_Time_Stamp,
    output logic        o_Alarm_Active,
    output logic        o_Snooze_Active,
    output logic        o_Buzzer,
    output logic [1:0]  o_State
);

    localparam int CAD_W  = (CADENCE_TICKS > 1) ? $clog2(CADENCE_TICKS) : 1;
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [15:0]       RING_LAST  = 16'(RING_TIMEOUT - 1);
    localparam logic [CAD_W-1:0]  CAD_LAST   = CAD_W'(CADENCE_TICKS - 1);
    localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(TONE_DIV - 1);
    localparam logic [24:0]       MAX_25     = 25'(MAX_COUNT);
    localparam logic [24:0]       SNOOZE_25  = 25'(SNOOZE_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                match_prev;
    logic [23:0]         prev_stamp;
    logic [23:0]         snooze_target;
    logic [15:0]         ring_cnt;
    logic [CAD_W-1:0]    cadence_cnt;
    logic                cadence_on;
    logic [TONE_W-1:0]   tone_cnt;
    logic                tone;

    logic [23:0]         target;
    logic                match;
    logic                fire;
    logic                tick;
    logic                load_snooze;
    logic                ring_hold;
    logic [24:0]         snooze_sum;
    logic [23:0]         snooze_next;

    // While snoozing, the snooze target replaces the programmed alarm time.
    assign target = (state == SNOOZE) ? snooze_target : i_Alarm_Time_Stamp;
    assign match  = (i_Time_Stamp == target);
    // Rising edge of the match: fires once per stamp arrival on the target,
    // never while the stamp merely sits there or when enable rises late.
    assign fire   = match & ~match_prev & i_Alarm_Enable;
    assign tick   = (i_Time_Stamp != prev_stamp);

    // Counters only run while ringing continues; any entry into RINGING
    // starts them from zero.
    assign ring_hold = (state == RINGING) && (next_state == RINGING);

    // Snooze target wraps past midnight; the extra bit keeps the sum exact.
    always_comb begin
        snooze_sum = {1'b0, i_Time_Stamp} + SNOOZE_25;
        if (snooze_sum >= MAX_25) begin
            snooze_next = 24'(snooze_sum - MAX_25);
        end else begin
            snooze_next = 24'(snooze_sum);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        load_snooze = 1'b0;
        if (!i_Alarm_Enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) next_state = RINGING;
                end
                RINGING: begin
                    if (i_Dismiss) begin
                        next_state = IDLE;
                    end else if (i_Snooze) begin
                        next_state  = SNOOZE;
                        load_snooze = 1'b1;
                    end else if (tick && ring_cnt == RING_LAST) begin
                        next_state = IDLE;
                    end
                end
                SNOOZE: begin
                    if (i_Dismiss) begin
                        next_state = IDLE;
                    end else if (fire) begin
                        next_state = RINGING;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state         <= IDLE;
            match_prev    <= 1'b1;
            prev_stamp    <= '0;
            snooze_target <= '0;
        end else begin
            state      <= next_state;
            match_prev <= match;
            prev_stamp <= i_Time_Stamp;
            if (load_snooze) snooze_target <= snooze_next;
        end
    end

    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ring_cnt    <= '0;
            cadence_cnt <= '0;
            cadence_on  <= 1'b0;
            tone_cnt    <= '0;
            tone        <= 1'b0;
        end else if (!ring_hold) begin
            // Parked at zero with the cadence in its "on" half, ready for the
            // next ring to start audible.
            ring_cnt    <= '0;
            cadence_cnt <= '0;
            cadence_on  <= 1'b1;
            tone_cnt    <= '0;
            tone        <= 1'b0;
        end else begin
            if (tick) begin
                ring_cnt <= ring_cnt + 16'd1;
                if (cadence_cnt == CAD_LAST) begin
                    cadence_cnt <= '0;
                    cadence_on  <= ~cadence_on;
                end else begin
                    cadence_cnt <= cadence_cnt + CAD_W'(1);
                end
            end
            if (tone_cnt == TONE_LAST) begin
                tone_cnt <= '0;
                tone     <= ~tone;
            end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Alarm_Active  <= 1'b0;
            o_Snooze_Active <= 1'b0;
            o_Buzzer        <= 1'b0;
        end else begin
            o_Alarm_Active  <= (next_state == RINGING);
            o_Snooze_Active <= (next_state == SNOOZE);
            o_Buzzer        <= ring_hold & tone & cadence_on;
        end
    end

    assign o_State = state;

endmodule

// File: tb/tb_alarm_trigger.sv
`timescale 1ns/1ps
module tb_alarm_trigger;

    localparam int MAX = 8640000;
    localparam int SN  = 30000;
    localparam int RT  = 6000;
    localparam int CAD = 50;
    localparam int TD  = 2500;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        snz   = 1'b0;
    logic        dis   = 1'b0;
    logic [23:0] ts    = '0;
    logic [23:0] alarm = '0;

    logic        alarm_active;
    logic        snooze_active;
    logic        buzzer;
    logic [1:0]  state_out;

    always #100 clk = ~clk;

    alarm_trigger #(
        .MAX_COUNT    (MAX),
        .SNOOZE_TICKS (SN),
        .RING_TIMEOUT (RT),
        .CADENCE_TICKS(CAD),
        .TONE_DIV     (TD)
    ) dut (
        .i_Clk_5MHz        (clk),
        .i_Reset_n         (rst_n),
        .i_Alarm_Enable    (en),
        .i_Snooze          (snz),
        .i_Dismiss         (dis),
        .i_Time_Stamp      (ts),
        .i_Alarm_Time_Stamp(alarm),
        .o_Alarm_Active    (alarm_active),
        .o_Snooze_Active   (snooze_active),
        .o_Buzzer          (buzzer),
        .o_State           (state_out)
    );

    typedef struct {
        int state;
        bit ring;
        bit snooze;
        bit buzz;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string phase = "reset";

    // Reference model: mode (0 idle, 1 ringing, 2 snooze), plus the elapsed
    // clocks and stamp changes since the ring began.
    int m_state;
    bit m_prev_match;
    int m_prev_stamp;
    int m_snooze_target;
    int m_ticks;
    int m_clocks;
    bit m_audible;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s [%s] @%0t: got %0d, expected %0d", name, phase, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state         = 0;
        m_prev_match    = 1'b1;
        m_prev_stamp    = 0;
        m_snooze_target = 0;
        m_ticks         = 0;
        m_clocks        = 0;
        m_audible       = 1'b0;
    endtask

    // Drive one cycle of inputs and push what the outputs must be after the
    // next rising edge.
    task automatic drive_and_push(input bit e, input bit s, input bit d, input int t);
        int   target;
        bit   match;
        bit   fire;
        bit   tick;
        int   nxt;
        bit   buzz;
        exp_t x;
        en  = e;
        snz = s;
        dis = d;
        ts  = 24'(t);

        target = (m_state == 2) ? m_snooze_target : int'(alarm);
        match  = (t == target);
        fire   = match && !m_prev_match && e;
        tick   = (t != m_prev_stamp);

        nxt = m_state;
        if (!e) begin
            nxt = 0;
        end else if (m_state == 0) begin
            if (fire) nxt = 1;
        end else if (m_state == 1) begin
            if (d) nxt = 0;
            else if (s) begin
                nxt = 2;
                m_snooze_target = (t + SN) % MAX;
            end else if (tick && (m_ticks + 1) == RT) nxt = 0;
        end else begin
            if (d) nxt = 0;
            else if (fire) nxt = 1;
        end

        if (m_state == 1 && nxt == 1) begin
            m_clocks++;
            if (tick) m_ticks++;
            buzz = m_audible;
        end else begin
            m_clocks = 0;
            m_ticks  = 0;
            buzz     = 1'b0;
        end
        // Tone is high in odd half-periods; cadence is on in even halves.
        if (nxt == 1)
            m_audible = (((m_clocks / TD) % 2) == 1) && (((m_ticks / CAD) % 2) == 0);
        else
            m_audible = 1'b0;

        m_prev_match = match;
        m_prev_stamp = t;
        m_state      = nxt;

        x.state  = nxt;
        x.ring   = (nxt == 1);
        x.snooze = (nxt == 2);
        x.buzz   = buzz;
        exp_q.push_back(x);
    endtask

    task automatic step(input bit e, input bit s, input bit d, input int t);
        @(negedge clk);
        drive_and_push(e, s, d, t);
    endtask

    task automatic hold(input int n, input int t);
        for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, t);
    endtask

    // Monitor: every expected entry corresponds to one rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("o_State",         int'(state_out),     x.state);
                check("o_Alarm_Active",  int'(alarm_active),  int'(x.ring));
                check("o_Snooze_Active", int'(snooze_active), int'(x.snooze));
                check("o_Buzzer",        int'(buzzer),        int'(x.buzz));
            end
        end
    end

    initial begin
        #(200 * 100000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;
        bit e;
        bit s;
        bit d;

        model_reset();
        alarm = 24'd2520000;
        ts    = 24'd2519999;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset o_State",         int'(state_out),     0);
        check("reset o_Alarm_Active",  int'(alarm_active),  0);
        check("reset o_Snooze_Active", int'(snooze_active), 0);
        check("reset o_Buzzer",        int'(buzzer),        0);

        // Basic ring, long hold on target, dismiss.
        phase = "basic";
        @(negedge clk);
        rst_n = 1'b1;
        drive_and_push(1'b1, 1'b0, 1'b0, 2519999);
        hold(2, 2519999);
        step(1'b1, 1'b0, 1'b0, 2520000);
        hold(100, 2520000);
        step(1'b1, 1'b0, 1'b1, 2520000);
        hold(3, 2520000);

        // Snooze from stamp 2520100, re-ring at 2550100.
        phase = "snooze";
        step(1'b1, 1'b0, 1'b0, 2519999);
        step(1'b1, 1'b0, 1'b0, 2520000);
        for (int i = 1; i <= 100; i++) step(1'b1, 1'b0, 1'b0, 2520000 + i);
        step(1'b1, 1'b1, 1'b0, 2520100);
        hold(3, 2520100);
        hold(3, 2550099);
        step(1'b1, 1'b0, 1'b0, 2550100);
        hold(3, 2550100);
        step(1'b1, 1'b0, 1'b1, 2550100);

        // Snooze target wraps through midnight.
        phase = "snooze_wrap";
        alarm = 24'd8630000;
        step(1'b1, 1'b0, 1'b0, 8629999);
        step(1'b1, 1'b0, 1'b0, 8630000);
        step(1'b1, 1'b1, 1'b0, 8630000);
        hold(2, 8639998);
        hold(2, 8639999);
        hold(2, 0);
        hold(2, 1);
        hold(2, 19999);
        hold(3, 20000);
        step(1'b1, 1'b0, 1'b1, 20000);

        // Ring timeout; slow early ticks expose tone and cadence.
        phase = "timeout";
        alarm = 24'd1000;
        step(1'b1, 1'b0, 1'b0, 999);
        step(1'b1, 1'b0, 1'b0, 1000);
        for (int i = 1; i <= RT; i++) begin
            step(1'b1, 1'b0, 1'b0, 1000 + i);
            if (i <= 120) hold(59, 1000 + i);
        end
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 1000 + RT + i);

        phase = "snooze_and_dismiss";
        alarm = 24'd50000;
        step(1'b1, 1'b0, 1'b0, 49999);
        step(1'b1, 1'b0, 1'b0, 50000);
        step(1'b1, 1'b1, 1'b1, 50000);
        hold(2, 50000);

        phase = "disable_in_snooze";
        step(1'b1, 1'b0, 1'b0, 49999);
        step(1'b1, 1'b0, 1'b0, 50000);
        step(1'b1, 1'b1, 1'b0, 50000);
        hold(3, 50000);
        step(1'b0, 1'b0, 1'b0, 50000);
        hold(2, 50000);

        phase = "enable_on_target";
        step(1'b0, 1'b0, 1'b0, 49999);
        step(1'b0, 1'b0, 1'b0, 50000);
        hold(3, 50000);
        step(1'b1, 1'b0, 1'b0, 50000);
        hold(5, 50000);

        phase = "time_jump";
        alarm = 24'd2520000;
        hold(2, 2519000);
        step(1'b1, 1'b0, 1'b0, 2520000);
        hold(2600, 2520000);

        // Asynchronous reset while the buzzer sounds.
        phase = "async_reset";
        @(posedge clk);
        #37;
        rst_n = 1'b0;
        #1;
        check("async reset o_State",         int'(state_out),     0);
        check("async reset o_Alarm_Active",  int'(alarm_active),  0);
        check("async reset o_Snooze_Active", int'(snooze_active), 0);
        check("async reset o_Buzzer",        int'(buzzer),        0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_and_push(1'b1, 1'b0, 1'b0, 2520000);
        hold(5, 2520000);

        // Randomised traffic around a random alarm time.
        phase = "random";
        alarm = 24'($urandom_range(0, MAX - 1));
        t     = (int'(alarm) + MAX - 3) % MAX;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      t = (t + 1) % MAX;
            else if (r < 55) t = int'(alarm);
            else if (r < 60) t = m_snooze_target;
            else if (r < 63) t = int'($urandom_range(0, MAX - 1));
            else if (r < 67) t = (int'(alarm) + MAX - 1) % MAX;
            e = en;
            if ($urandom_range(0, 99) < 2) e = ~en;
            s = ($urandom_range(0, 99) < 6);
            d = ($urandom_range(0, 99) < 3);
            step(e, s, d, t);
        end

        phase = "drain";
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
- Consumes the 24-bit alarm time stamp from the alarm-time stage and the running clock's 24-bit time stamp. Both stamps count hundredths of a second since midnight, range 0..MAX_COUNT-1.
- Decides when the alarm rings, handles snooze and dismiss, enforces a ring timeout, and generates the gated buzzer square wave for the speaker pin.

Parameters:
- MAX_COUNT, 8640000, stamp modulus (one day in hundredths).
- SNOOZE_TICKS, 30000, snooze length in stamp ticks (5 min). Must be < MAX_COUNT.
- RING_TIMEOUT, 6000, stamp ticks of ringing before auto-stop (60 s). Must be < 65536.
- CADENCE_TICKS, 50, stamp ticks per buzzer on/off half-cadence (0.5 s).
- TONE_DIV, 2500, clocks per tone half-period (1 kHz at 5 MHz).

Ports:
- i_Clk_5MHz  in  1  system clock. One clock only.
- i_Reset_n  in  1  reset, asynchronous, active-low.
- i_Alarm_Enable  in  1  level; alarm armed when 1.
- i_Snooze  in  1  single-cycle pulse, pre-debounced.
- i_Dismiss  in  1  single-cycle pulse, pre-debounced.
- i_Time_Stamp  in  24  current time, hundredths.
- i_Alarm_Time_Stamp  in  24  alarm time, hundredths.
- o_Alarm_Active  out  1  1 while RINGING.
- o_Snooze_Active  out  1  1 while SNOOZE.
- o_Buzzer  out  1  gated tone output.
- o_State  out  2  0=IDLE, 1=RINGING, 2=SNOOZE.

Behaviour:
- Reset (async, i_Reset_n=0): state IDLE. All outputs 0. r_Match_Prev=1 (no fire on first cycle). r_Prev_Stamp=0. Ring, cadence and tone counters 0. Snooze target 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Target selection: target = i_Alarm_Time_Stamp in IDLE/RINGING, r_Snooze_Target in SNOOZE.
- Match: w_Match = (i_Time_Stamp == target). r_Match_Prev <= w_Match every cycle in every state, independent of enable.
- Fire = w_Match & ~r_Match_Prev & i_Alarm_Enable.
  - Fires once per stamp arrival, so there is no retrigger while the stamp sits on the target (50000 clocks).
  - A stamp jump straight onto the target (time set) fires.
  - Enabling while stamp == target does not fire.
- Tick = (i_Time_Stamp != r_Prev_Stamp). r_Prev_Stamp updates every cycle.
- State transitions, evaluated in priority order each cycle:
  - i_Alarm_Enable=0: any state -> IDLE.
  - IDLE: Fire -> RINGING. i_Snooze and i_Dismiss are ignored.
  - RINGING:
    - i_Dismiss -> IDLE. Dismiss beats snooze when both pulse in the same cycle.
    - else i_Snooze -> SNOOZE, with r_Snooze_Target <= i_Time_Stamp + SNOOZE_TICKS, minus MAX_COUNT if the sum >= MAX_COUNT (25-bit intermediate).
    - else ring counter reaches RING_TIMEOUT -> IDLE.
  - SNOOZE: i_Dismiss -> IDLE; else Fire -> RINGING. i_Snooze ignored.
- Latency: o_State/o_Alarm_Active change on the clock edge that samples the triggering condition. They are visible the cycle after the first cycle the stamp equals target.
- Entering RINGING (any source) clears the ring, cadence and tone counters and sets r_Cadence_On=1.
- In RINGING:
  - Ring counter +1 per Tick.
  - Cadence counter +1 per Tick; at CADENCE_TICKS-1 it wraps to 0 and toggles r_Cadence_On.
  - Tone counter counts 0..TONE_DIV-1 each clock and toggles r_Tone on wrap.
  - o_Buzzer <= r_Tone & r_Cadence_On.
- Outside RINGING, o_Buzzer <= 0 and the counters hold 0.
- Midnight wrap: stamp 8639999 -> 0 is an ordinary Tick. Matching is pure equality, so an alarm at 0 fires at wrap.
- Reset mid-ring forces IDLE immediately (async) and silences o_Buzzer.

Test Plan:
- Alarm 2520000, enable=1, stamp stepped 2519999 -> 2520000 -> o_Alarm_Active=1, o_State=1 one cycle after the match. Hold stamp 2520000 for 100 cycles -> no extra transitions. Dismiss -> o_State=0, o_Buzzer=0 next cycle.
- Ringing at stamp 2520100, i_Snooze pulse -> o_State=2, target 2550100. Stamp 2550099 -> stays 2. Stamp 2550100 -> RINGING.
- Snooze wrap: ringing at stamp 8630000, snooze -> target 20000. Stamp stepped through 8639999 -> 0 -> 20000 -> RINGING at 20000.
- Ring timeout: enter RINGING, apply 5999 ticks -> still 1. 6000th tick -> IDLE. Buzzer on for ticks 0..49, off for 50..99. While on, the tone period is 5000 clocks.
- Snooze and dismiss in the same cycle while RINGING -> IDLE. Enable dropped in SNOOZE -> IDLE. Enable raised with stamp == alarm -> no ring. Stamp jumped 2519000 -> 2520000 -> ring.
- Assert i_Reset_n=0 mid-ring, asynchronous to clock -> all outputs 0 immediately. After release, stamp == alarm for the first cycle -> no fire.
